// File: rtl/hwag_spi_slave_phy_if.sv
// hwag_spi_slave_phy_if
//   Pin and byte-level bundle between an SPI master (or bench) and the
//   hwag_spi_slave_phy deserialiser.
//   Raw pins  : spi_sck, spi_mosi, spi_ss_n (master -> slave), spi_miso (slave -> master)
//   Byte side : spi_bus_in (next response byte), spi_ss, spi_bus_out, spi_rx,
//               spi_crc_rx_out (slave -> frame receiver)
interface hwag_spi_slave_phy_if;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_ss_n;
  logic [7:0] spi_bus_in;
  logic       spi_ss;
  logic [7:0] spi_bus_out;
  logic       spi_rx;
  logic [7:0] spi_crc_rx_out;
  logic       spi_miso;

  modport slave (
    input  spi_sck, spi_mosi, spi_ss_n, spi_bus_in,
    output spi_ss, spi_bus_out, spi_rx, spi_crc_rx_out, spi_miso
  );

  modport master (
    output spi_sck, spi_mosi, spi_ss_n, spi_bus_in,
    input  spi_ss, spi_bus_out, spi_rx, spi_crc_rx_out, spi_miso
  );
endinterface

// File: rtl/hwag_spi_slave_phy.sv
// hwag_spi_slave_phy
//   SPI mode-0 slave physical layer. Synchronises SCK/MOSI/SS into clk,
//   deserialises MOSI into bytes with a one-cycle spi_rx strobe, keeps a
//   running MSB-first CRC-8 over the frame and shifts response bytes out
//   on MISO.
//   Ports:
//     clk, rst : system clock, asynchronous active-high reset
//     spi      : hwag_spi_slave_phy_if.slave
//                in  spi_sck, spi_mosi, spi_ss_n, spi_bus_in[7:0]
//                out spi_ss (1 = idle), spi_bus_out[7:0], spi_rx,
//                    spi_crc_rx_out[7:0], spi_miso
module hwag_spi_slave_phy #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter logic [7:0]  CRC_INIT    = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  hwag_spi_slave_phy_if.slave spi
);

  localparam int unsigned SS = SYNC_STAGES;

  logic [SS-1:0] sck_sync_q,  sck_sync_d;
  logic [SS-1:0] mosi_sync_q, mosi_sync_d;
  logic [SS-1:0] ss_sync_q,   ss_sync_d;
  logic [SS-1:0] ss_vld_q,    ss_vld_d;
  logic          sck_prev_q,  sck_prev_d;
  logic          ss_prev_q,   ss_prev_d;
  logic          frame_ok_q,  frame_ok_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic [6:0]    shift_q,     shift_d;
  logic [7:0]    bus_q,       bus_d;
  logic          rx_q,        rx_d;
  logic [7:0]    crc_q,       crc_d;
  logic [7:0]    tx_q,        tx_d;
  logic          armed_q,     armed_d;

  logic sck_s, mosi_s, ss_raw, ss_eff;
  logic sck_rise, sck_fall, ss_fall;

  // MSB-first, non-reflected CRC-8 over one byte.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
    return c;
  endfunction

  assign sck_s  = sck_sync_q[SS-1];
  assign mosi_s = mosi_sync_q[SS-1];
  assign ss_raw = ss_sync_q[SS-1];
  // After reset the select stays idle until the pin has really been seen
  // deselected, so a frame interrupted by reset is never resumed mid-byte.
  assign ss_eff   = ss_raw | ~frame_ok_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ss_prev_q & ~ss_eff;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SS-2:0],  spi.spi_sck};
    mosi_sync_d = {mosi_sync_q[SS-2:0], spi.spi_mosi};
    ss_sync_d   = {ss_sync_q[SS-2:0],   spi.spi_ss_n};
    ss_vld_d    = {ss_vld_q[SS-2:0],    1'b1};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_eff;
    frame_ok_d  = frame_ok_q | (ss_vld_q[SS-1] & ss_raw);

    cnt_d   = cnt_q;
    shift_d = shift_q;
    bus_d   = bus_q;
    rx_d    = 1'b0;
    crc_d   = crc_q;
    tx_d    = tx_q;
    armed_d = armed_q;

    if (ss_eff) begin
      cnt_d   = 3'd0;
      shift_d = 7'd0;
      crc_d   = CRC_INIT;
      tx_d    = 8'h00;
      armed_d = 1'b0;
    end else begin
      if (sck_rise) begin
        shift_d = {shift_q[5:0], mosi_s};
        cnt_d   = cnt_q + 3'd1;
        armed_d = 1'b0;
        if (cnt_q == 3'd7) begin
          bus_d = {shift_q, mosi_s};
          rx_d  = 1'b1;
        end
      end
      if (rx_q) begin
        crc_d = crc8_update(crc_q, bus_q);
      end
      if (ss_fall || rx_q) begin
        tx_d    = spi.spi_bus_in;
        armed_d = 1'b1;
      end else if (sck_fall) begin
        // The trailing fall of the previous byte arrives after the reload;
        // it must not consume the MSB of the freshly loaded byte.
        if (armed_q && (cnt_q == 3'd0)) begin
          armed_d = 1'b0;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      ss_vld_q    <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      frame_ok_q  <= 1'b0;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      bus_q       <= 8'h00;
      rx_q        <= 1'b0;
      crc_q       <= CRC_INIT;
      tx_q        <= 8'h00;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      ss_vld_q    <= ss_vld_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      frame_ok_q  <= frame_ok_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bus_q       <= bus_d;
      rx_q        <= rx_d;
      crc_q       <= crc_d;
      tx_q        <= tx_d;
      armed_q     <= armed_d;
    end
  end

  assign spi.spi_ss         = ss_eff;
  assign spi.spi_bus_out    = bus_q;
  assign spi.spi_rx         = rx_q;
  assign spi.spi_crc_rx_out = crc_q;
  assign spi.spi_miso       = ss_eff ? 1'b0 : tx_q[7];

endmodule

// File: tb/tb_hwag_spi_slave_phy.sv
// tb_hwag_spi_slave_phy
//   Directed bench for hwag_spi_slave_phy: a mode-0 master driven from one
//   initial block, a strobe monitor recording every received byte with the
//   CRC seen during and after its strobe.
module tb_hwag_spi_slave_phy;

  logic clk;
  logic rst;

  hwag_spi_slave_phy_if bus ();

  hwag_spi_slave_phy dut (
    .clk (clk),
    .rst (rst),
    .spi (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_byte     [0:63];
  logic [7:0] rx_crc_pre  [0:63];
  logic [7:0] rx_crc_post [0:63];
  int         rx_cnt = 0;
  bit         post_pending = 1'b0;

  always @(negedge clk) begin
    if (post_pending) begin
      rx_crc_post[rx_cnt-1] = bus.spi_crc_rx_out;
      post_pending = 1'b0;
    end
    if (bus.spi_rx === 1'b1 && rx_cnt < 64) begin
      rx_byte[rx_cnt]    = bus.spi_bus_out;
      rx_crc_pre[rx_cnt] = bus.spi_crc_rx_out;
      rx_cnt++;
      post_pending = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: XOR the byte in, then eight polynomial steps.
  function automatic logic [7:0] crc_ref(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    bus.spi_ss_n = 1'b0;
    tick(6);
  endtask

  task automatic ss_high();
    bus.spi_ss_n = 1'b1;
    tick(10);
  endtask

  // Sends the top nbits of b MSB-first; returns MISO as sampled at each rise.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      tick(4);
      mi = {mi[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      tick(4);
      bus.spi_sck = 1'b0;
    end
  endtask

  initial begin
    int         base;
    logic [7:0] mi, mi0, mi1, crc_ok, crc_bad;
    logic [7:0] frame [0:5];

    rst = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_bus_in = 8'h00;
    tick(3);
    check("reset_ss",      bus.spi_ss,         1'b1);
    check("reset_bus_out", bus.spi_bus_out,    8'h00);
    check("reset_rx",      bus.spi_rx,         1'b0);
    check("reset_crc",     bus.spi_crc_rx_out, 8'h00);
    check("reset_miso",    bus.spi_miso,       1'b0);
    rst = 1'b0;
    tick(6);

    // Single byte 0xA5
    base = rx_cnt;
    ss_low();
    send_bits(8'hA5, 8, mi);
    ss_high();
    check("single_count",   rx_cnt - base,        1);
    check("single_byte",    rx_byte[base],        8'hA5);
    check("single_crc_pre", rx_crc_pre[base],     8'h00);
    check("single_hold",    bus.spi_bus_out,      8'hA5);
    check("idle_ss",        bus.spi_ss,           1'b1);

    // CRC check vector "123456789"
    base = rx_cnt;
    ss_low();
    for (int j = 0; j < 9; j++) send_bits(8'h31 + j[7:0], 8, mi);
    ss_high();
    check("crc9_count",     rx_cnt - base,         9);
    check("crc9_last_byte", rx_byte[base+8],       8'h39);
    check("crc9_final",     rx_crc_post[base+8],   8'hF4);
    check("crc_idle_init",  bus.spi_crc_rx_out,    8'h00);

    // 0x01 then 0x02
    base = rx_cnt;
    ss_low();
    send_bits(8'h01, 8, mi);
    send_bits(8'h02, 8, mi);
    ss_high();
    check("crc01_pre",   rx_crc_pre[base],    8'h00);
    check("crc01_post",  rx_crc_post[base],   8'h07);
    check("crc02_pre",   rx_crc_pre[base+1],  8'h07);
    check("crc02_post",  rx_crc_post[base+1], 8'h1B);

    // Frame with trailing CRC byte, then one-bit corruption
    frame[0] = 8'h01; frame[1] = 8'h10; frame[2] = 8'h44;
    frame[3] = 8'h33; frame[4] = 8'h22; frame[5] = 8'h11;
    crc_ok = 8'h00;
    for (int j = 0; j < 6; j++) crc_ok = crc_ref(crc_ok, frame[j]);
    base = rx_cnt;
    ss_low();
    for (int j = 0; j < 6; j++) send_bits(frame[j], 8, mi);
    send_bits(crc_ok, 8, mi);
    ss_high();
    check("frame_count",     rx_cnt - base,          7);
    check("frame_crc_equal", rx_crc_pre[base+6],     crc_ok);
    check("frame_residue",   rx_crc_post[base+6],    8'h00);
    frame[5] = 8'h10;
    crc_bad = 8'h00;
    for (int j = 0; j < 6; j++) crc_bad = crc_ref(crc_bad, frame[j]);
    base = rx_cnt;
    ss_low();
    for (int j = 0; j < 6; j++) send_bits(frame[j], 8, mi);
    send_bits(crc_ok, 8, mi);
    ss_high();
    check("corrupt_crc",      rx_crc_pre[base+6],            crc_bad);
    check("corrupt_differs",  rx_crc_pre[base+6] != crc_ok,  1'b1);

    // Abort after 5 bits, then a fresh frame of 0x3C
    base = rx_cnt;
    ss_low();
    send_bits(8'hFF, 5, mi);
    ss_high();
    check("abort_no_strobe", rx_cnt - base, 0);
    ss_low();
    send_bits(8'h3C, 8, mi);
    ss_high();
    check("abort_count",    rx_cnt - base,       1);
    check("abort_byte",     rx_byte[base],       8'h3C);
    check("abort_crc_pre",  rx_crc_pre[base],    8'h00);
    check("abort_crc_post", rx_crc_post[base],   8'hB4);

    // MISO response bytes
    bus.spi_bus_in = 8'h96;
    ss_low();
    bus.spi_bus_in = 8'h5A;
    send_bits(8'h0F, 8, mi0);
    bus.spi_bus_in = 8'h33;
    send_bits(8'hC3, 8, mi1);
    ss_high();
    check("miso_byte0", mi0, 8'h96);
    check("miso_byte1", mi1, 8'h5A);
    bus.spi_bus_in = 8'hFF;
    tick(4);
    check("miso_idle", bus.spi_miso, 1'b0);

    // Deselect coinciding with the 8th rising edge drops the byte
    base = rx_cnt;
    ss_low();
    send_bits(8'hAA, 7, mi);
    bus.spi_mosi = 1'b1;
    tick(4);
    bus.spi_sck = 1'b1;
    bus.spi_ss_n = 1'b1;
    tick(4);
    bus.spi_sck = 1'b0;
    tick(10);
    check("prio_no_strobe", rx_cnt - base,   0);
    check("prio_bus_hold",  bus.spi_bus_out, 8'hC3);

    // Reset during byte 3
    bus.spi_bus_in = 8'hFF;
    ss_low();
    send_bits(8'h11, 8, mi);
    send_bits(8'h22, 8, mi);
    send_bits(8'h33, 3, mi);
    check("pre_reset_bus", bus.spi_bus_out, 8'h22);
    rst = 1'b1;
    #1;
    check("rst_ss",      bus.spi_ss,         1'b1);
    check("rst_bus_out", bus.spi_bus_out,    8'h00);
    check("rst_rx",      bus.spi_rx,         1'b0);
    check("rst_crc",     bus.spi_crc_rx_out, 8'h00);
    check("rst_miso",    bus.spi_miso,       1'b0);
    tick(2);
    rst = 1'b0;
    base = rx_cnt;
    send_bits(8'h55, 8, mi);
    send_bits(8'h55, 8, mi);
    check("post_rst_no_strobe", rx_cnt - base, 0);
    check("post_rst_ss_idle",   bus.spi_ss,    1'b1);
    ss_high();
    ss_low();
    send_bits(8'h5A, 8, mi);
    ss_high();
    check("restart_count", rx_cnt - base,    1);
    check("restart_byte",  rx_byte[base],    8'h5A);
    check("restart_crc",   rx_crc_pre[base], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
